// File: rtl/usb_proxy_pkg.sv
// ============================================================================
// Module      : usb_proxy_pkg
// Description : Shared definitions for the USB proxy: arbiter FSM state
//               encoding, framing marker defaults and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_proxy_pkg;

  // Arbiter FSM state encoding (3-bit, kept stable for legacy tooling)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SOF     = 3'd1;
  localparam logic [2:0] ST_ID      = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_ABORT   = 3'd4;

  // Frame marker defaults
  localparam logic [7:0] SOF_BYTE_DEFAULT   = 8'hA5;
  localparam logic [7:0] ABORT_BYTE_DEFAULT = 8'h5A;

  // Saturating 8-bit increment used by event counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. The search starts at
//               last_grant+1 and wraps modulo NUM_SRC; the first requester
//               found wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last_grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx
);

  localparam int GW = $clog2(NUM_SRC);

  logic [GW:0]   w_sum;
  logic [GW-1:0] w_cand;

  // Scan offsets from farthest to nearest so the nearest requester after
  // last_grant is the final (winning) assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_sum       = '0;
    w_cand      = '0;
    for (int off = NUM_SRC; off >= 1; off--) begin
      w_sum = {1'b0, last_grant} + (GW+1)'(off);
      if (w_sum >= (GW+1)'(NUM_SRC)) begin
        w_sum = w_sum - (GW+1)'(NUM_SRC);
      end
      w_cand = w_sum[GW-1:0];
      if (req[w_cand]) begin
        grant_valid = 1'b1;
        grant_idx   = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Multiplexes packets from NUM_SRC byte-stream sources onto one
//               UART TX FIFO. Each packet is framed as SOF, source ID, payload.
//               A packet stalled mid-stream is terminated with an abort byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import usb_proxy_pkg::*;
#(
  parameter int         NUM_SRC        = 4,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEFAULT,
  parameter logic [7:0] ABORT_BYTE     = ABORT_BYTE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*8-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [7:0]                 timeout_count
);

  localparam int            GW          = $clog2(NUM_SRC);
  localparam int            SW          = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] STALL_LIMIT = SW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          terr_q, terr_d;
  logic [7:0]    tcnt_q, tcnt_d;

  logic          w_out_free;
  logic          w_grant_valid;
  logic [GW-1:0] w_grant_idx;
  logic [7:0]    w_sel_data;
  logic          w_sel_valid;
  logic          w_sel_last;
  logic          w_src_hs;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr (
    .req         (src_valid),
    .last_grant  (last_grant_q),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // The output register can take a new byte when empty or draining this cycle
  assign w_out_free  = !tx_valid_q || tx_ready;
  assign w_sel_data  = src_data[{grant_q, 3'b000} +: 8];
  assign w_sel_valid = src_valid[grant_q];
  assign w_sel_last  = src_last[grant_q];
  assign w_src_hs    = (state_q == ST_PAYLOAD) && w_sel_valid && w_out_free;

  // Only the granted source sees ready, and only while streaming payload
  always_comb begin
    src_ready = '0;
    if (state_q == ST_PAYLOAD) begin
      src_ready[grant_q] = w_out_free;
    end
  end

  // Framing FSM and output register next-state logic
  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q && !tx_ready;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;
    terr_d       = 1'b0;
    tcnt_d       = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_grant_valid) begin
          grant_d = w_grant_idx;
          state_d = ST_SOF;
        end
      end
      ST_SOF: begin
        if (w_out_free) begin
          tx_data_d  = SOF_BYTE;
          tx_valid_d = 1'b1;
          state_d    = ST_ID;
        end
      end
      ST_ID: begin
        if (w_out_free) begin
          tx_data_d  = 8'(grant_q);
          tx_valid_d = 1'b1;
          stall_d    = '0;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_src_hs) begin
          tx_data_d  = w_sel_data;
          tx_valid_d = 1'b1;
          stall_d    = '0;
          if (w_sel_last) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end else if (stall_q == STALL_LIMIT) begin
          state_d = ST_ABORT;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      ST_ABORT: begin
        if (w_out_free) begin
          tx_data_d    = ABORT_BYTE;
          tx_valid_d   = 1'b1;
          terr_d       = 1'b1;
          tcnt_d       = sat_inc8(tcnt_q);
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any partial frame without an abort byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
      stall_q      <= '0;
      terr_q       <= 1'b0;
      tcnt_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
      terr_q       <= terr_d;
      tcnt_q       <= tcnt_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_err   = terr_q;
  assign timeout_count = tcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter. Two instances share the
//               stimulus: one with a short stall limit, one with the default.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N*8-1:0] src_data;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_last;
  logic           tx_ready;
  logic           sel_to;

  logic [N-1:0] rdy_a, rdy_b;
  logic [7:0]   txd_a, txd_b, tc_a, tc_b;
  logic         txv_a, txv_b, busy_a, busy_b, te_a, te_b;
  logic [1:0]   gid_a, gid_b;

  logic [N-1:0] m_rdy;
  logic [7:0]   m_txd, m_tc;
  logic         m_txv, m_busy, m_te;
  logic [1:0]   m_gid;

  logic [8:0]   src_q [N][$];
  logic [7:0]   exp_q [$];
  logic [N-1:0] hs_pend;
  int           n_chk;
  int           n_err;
  int           n_te;

  uart_tx_arbiter #(.NUM_SRC(N), .TIMEOUT_CYCLES(16)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(rdy_a), .tx_data(txd_a), .tx_valid(txv_a),
    .tx_ready(tx_ready), .grant_id(gid_a), .busy(busy_a),
    .timeout_err(te_a), .timeout_count(tc_a)
  );

  uart_tx_arbiter #(.NUM_SRC(N)) u_dut_nt (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(rdy_b), .tx_data(txd_b), .tx_valid(txv_b),
    .tx_ready(tx_ready), .grant_id(gid_b), .busy(busy_b),
    .timeout_err(te_b), .timeout_count(tc_b)
  );

  assign m_rdy  = sel_to ? rdy_a  : rdy_b;
  assign m_txd  = sel_to ? txd_a  : txd_b;
  assign m_txv  = sel_to ? txv_a  : txv_b;
  assign m_busy = sel_to ? busy_a : busy_b;
  assign m_te   = sel_to ? te_a   : te_b;
  assign m_tc   = sel_to ? tc_a   : tc_b;
  assign m_gid  = sel_to ? gid_a  : gid_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic hdr(input int s);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(s));
  endtask

  task automatic src_byte(input int s, input logic [7:0] b, input logic last);
    src_q[s].push_back({last, b});
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n    = 1'b0;
    tx_ready = 1'b1;
    for (int s = 0; s < N; s++) src_q[s].delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    n_te  = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int max_cycles);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || m_busy) && i < max_cycles) begin
      @(posedge clk); #1;
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("busy_end", 32'(m_busy), 32'd0);
  endtask

  // Source drivers: retire the byte accepted at the last edge, present the next
  initial begin
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < N; s++) begin
        if (hs_pend[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
        if (src_q[s].size() > 0) begin
          src_valid[s]        = 1'b1;
          src_last[s]         = src_q[s][0][8];
          src_data[s*8 +: 8]  = src_q[s][0][7:0];
        end else begin
          src_valid[s] = 1'b0;
          src_last[s]  = 1'b0;
        end
      end
    end
  end

  // Monitor: inputs are stable from the negedge through the next posedge
  initial begin
    hs_pend = '0;
    forever begin
      @(negedge clk);
      hs_pend = src_valid & m_rdy;
      if (m_te) n_te++;
      if (rst_n && m_txv && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("tx_extra", 32'(m_txd), 32'h100);
        end else begin
          check("tx_byte", 32'(m_txd), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   i;
    logic found;
    n_chk    = 0;
    n_err    = 0;
    n_te     = 0;
    sel_to   = 1'b0;
    tx_ready = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txv", 32'(m_txv), 32'd0);
    check("rst_txd", 32'(m_txd), 32'd0);
    check("rst_rdy", 32'(m_rdy), 32'd0);
    check("rst_gid", 32'(m_gid), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_terr", 32'(m_te), 32'd0);
    check("rst_tcnt", 32'(m_tc), 32'd0);
    #1 rst_n = 1'b1;

    // Three-byte packet from source 2
    hdr(2);
    src_byte(2, 8'h11, 1'b0);
    src_byte(2, 8'h22, 1'b0);
    src_byte(2, 8'h33, 1'b1);
    wait_done(100);
    check("gid_src2", 32'(m_gid), 32'd2);

    // Sources 0 and 1 contend with single-byte packets: frames alternate
    do_reset();
    for (int k = 0; k < 2; k++) begin
      hdr(0); src_byte(0, 8'h40 + 8'(k), 1'b1);
      hdr(1); src_byte(1, 8'h50 + 8'(k), 1'b1);
    end
    wait_done(200);

    // Backpressure for 20 cycles while byte 22 sits in the output register
    do_reset();
    hdr(2);
    src_byte(2, 8'h11, 1'b0);
    src_byte(2, 8'h22, 1'b0);
    src_byte(2, 8'h33, 1'b1);
    found = 1'b0;
    i = 0;
    while (!found && i < 50) begin
      @(posedge clk); #1;
      if (m_txv && m_txd == 8'h22) found = 1'b1;
      i++;
    end
    check("see_22", 32'(found), 32'd1);
    tx_ready = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("hold_txd", 32'(m_txd), 32'h22);
      check("hold_txv", 32'(m_txv), 32'd1);
      check("hold_rdy2", 32'(m_rdy[2]), 32'd0);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_done(100);

    // Stall timeout on source 3 (short-limit instance)
    sel_to = 1'b1;
    do_reset();
    hdr(3);
    src_byte(3, 8'h77, 1'b0);
    exp_q.push_back(8'h5A);
    wait_done(200);
    check("terr_pulses", 32'(n_te), 32'd1);
    check("tcount_one", 32'(m_tc), 32'd1);

    // Reset right after the ID byte: frame is discarded, no abort byte
    sel_to = 1'b0;
    do_reset();
    hdr(0);
    src_q[0].push_back({1'b0, 8'h11});
    src_q[0].push_back({1'b1, 8'h12});
    i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check("id_sent", 32'(exp_q.size()), 32'd0);
    #1;
    rst_n = 1'b0;
    for (int s = 0; s < N; s++) src_q[s].delete();
    @(negedge clk);
    check("rst_mid_txv", 32'(m_txv), 32'd0);
    check("rst_mid_busy", 32'(m_busy), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    hdr(0);
    src_byte(0, 8'h44, 1'b1);
    wait_done(100);
    check("no_abort_te", 32'(n_te), 32'd0);
    check("no_abort_cnt", 32'(m_tc), 32'd0);

    // Payload byte equal to SOF passes verbatim
    do_reset();
    hdr(1);
    src_byte(1, 8'hA5, 1'b0);
    src_byte(1, 8'hB6, 1'b1);
    wait_done(100);
    check("a5_gid", 32'(m_gid), 32'd1);
    check("a5_tcnt", 32'(m_tc), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
